main_control_fsm: RTL and testbench

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

---
 rtl/main_control_fsm.sv | 192 +++++++++++++++++++
 tb/tb_main_control_fsm.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_control_fsm.sv
// Multi-cycle processor main control FSM.
//
// Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB and
// drives the datapath strobes and mux selects for every state. Illegal
// opcodes either halt the machine or are skipped, selected by ILLEGAL_HALT.
//
// Ports:
//   clk          - clock, all state changes on the rising edge
//   rst_n        - asynchronous active-low reset
//   opcode       - instruction opcode, valid from DECODE onward
//   zero, lt     - ALU flags (result equals zero, signed A < B)
//   mem_ready    - memory access complete (only looked at in FETCH and MEM)
//   alu_op       - operation class for the ALU control unit
//   pc_write, ir_write, mem_read, mem_write, reg_write - datapath strobes
//   mem_to_reg, alu_src_imm, branch_taken              - mux selects / branch flag
//   illegal      - illegal-opcode indication
//   state        - current state encoding (FETCH=0 ... HALT=5)

module main_control_fsm #(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       lt,
    input  logic       mem_ready,
    output logic [3:0] alu_op,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       alu_src_imm,
    output logic       branch_taken,
    output logic       illegal,
    output logic [2:0] state
);

    localparam logic [3:0] OpRtype = 4'b0000;
    localparam logic [3:0] OpAddi  = 4'b0001;
    localparam logic [3:0] OpOri   = 4'b0011;
    localparam logic [3:0] OpLw    = 4'b0111;
    localparam logic [3:0] OpSw    = 4'b1000;
    localparam logic [3:0] OpBeq   = 4'b1001;
    localparam logic [3:0] OpBne   = 4'b1010;
    localparam logic [3:0] OpBlt   = 4'b1011;
    localparam logic [3:0] OpBgt   = 4'b1100;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] op_q;

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            OpRtype, OpAddi, OpOri, OpLw, OpSw,
            OpBeq, OpBne, OpBlt, OpBgt: is_legal = 1'b1;
            default:                    is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic uses_imm(input logic [3:0] op);
        uses_imm = (op == OpAddi) || (op == OpOri) || (op == OpLw) || (op == OpSw);
    endfunction

    // Branch condition; non-branch opcodes never take a branch.
    function automatic logic branch_cond(input logic [3:0] op, input logic z, input logic l);
        case (op)
            OpBeq:   branch_cond = z;
            OpBne:   branch_cond = !z;
            OpBlt:   branch_cond = l;
            OpBgt:   branch_cond = !l && !z;
            default: branch_cond = 1'b0;
        endcase
    endfunction

    // State register and opcode latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            op_q    <= 4'b0000;
        end else begin
            state_q <= state_d;
            // Only legal opcodes are captured, so EXEC/MEM/WB see a legal op_q.
            if (state_q == StDecode && is_legal(opcode)) begin
                op_q <= opcode;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: begin
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                if (is_legal(opcode))  state_d = StExec;
                else if (ILLEGAL_HALT) state_d = StHalt;
                else                   state_d = StFetch;
            end
            StExec: begin
                case (op_q)
                    OpRtype, OpAddi, OpOri: state_d = StWb;
                    OpLw, OpSw:             state_d = StMem;
                    default:                state_d = StFetch;
                endcase
            end
            StMem: begin
                if (mem_ready) state_d = (op_q == OpLw) ? StWb : StFetch;
            end
            StWb:    state_d = StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    // Output logic
    always_comb begin
        alu_op       = 4'b0000;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src_imm  = 1'b0;
        branch_taken = 1'b0;
        illegal      = 1'b0;
        case (state_q)
            StFetch: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            StDecode: begin
                // Decode looks at the live opcode; the latch is not loaded yet.
                illegal = !is_legal(opcode);
            end
            StExec: begin
                alu_op      = op_q;
                alu_src_imm = uses_imm(op_q);
                if (branch_cond(op_q, zero, lt)) begin
                    branch_taken = 1'b1;
                    pc_write     = 1'b1;
                end
            end
            StMem: begin
                alu_src_imm = uses_imm(op_q);
                if (op_q == OpLw) mem_read  = 1'b1;
                else              mem_write = 1'b1;
            end
            StWb: begin
                reg_write  = 1'b1;
                mem_to_reg = (op_q == OpLw);
            end
            StHalt: begin
                illegal = 1'b1;
            end
            default: ;
        endcase
        // Async reset puts state_q in FETCH at once, but FETCH drives mem_read;
        // gate everything so no strobe is visible while reset is held.
        if (!rst_n) begin
            alu_op       = 4'b0000;
            pc_write     = 1'b0;
            ir_write     = 1'b0;
            mem_read     = 1'b0;
            mem_write    = 1'b0;
            reg_write    = 1'b0;
            mem_to_reg   = 1'b0;
            alu_src_imm  = 1'b0;
            branch_taken = 1'b0;
            illegal      = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed testbench for main_control_fsm. Two instances share all inputs:
// dut (ILLEGAL_HALT=1) and dut0 (ILLEGAL_HALT=0). Outputs are packed into a
// 16-bit word and compared against hand-computed constants.

module tb_main_control_fsm;

    logic       clk;
    logic       rst_n;
    logic [3:0] opcode;
    logic       zero;
    logic       lt;
    logic       mem_ready;

    logic [3:0] alu_op,  alu_op0;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write;
    logic       mem_to_reg, alu_src_imm, branch_taken, illegal;
    logic [2:0] state;
    logic       pc_write0, ir_write0, mem_read0, mem_write0, reg_write0;
    logic       mem_to_reg0, alu_src_imm0, branch_taken0, illegal0;
    logic [2:0] state0;

    // Packed layout: [15:12] alu_op, then pc_write, ir_write, mem_read, mem_write,
    // reg_write, mem_to_reg, alu_src_imm, branch_taken, illegal, [2:0] state.
    localparam logic [15:0] PW  = 16'h0800;
    localparam logic [15:0] IW  = 16'h0400;
    localparam logic [15:0] MR  = 16'h0200;
    localparam logic [15:0] MW  = 16'h0100;
    localparam logic [15:0] RW  = 16'h0080;
    localparam logic [15:0] MTR = 16'h0040;
    localparam logic [15:0] ASI = 16'h0020;
    localparam logic [15:0] BT  = 16'h0010;
    localparam logic [15:0] IL  = 16'h0008;

    logic [15:0] obs, obs0, exp;
    int tests = 0;
    int fails = 0;

    assign obs  = {alu_op, pc_write, ir_write, mem_read, mem_write, reg_write,
                   mem_to_reg, alu_src_imm, branch_taken, illegal, state};
    assign obs0 = {alu_op0, pc_write0, ir_write0, mem_read0, mem_write0, reg_write0,
                   mem_to_reg0, alu_src_imm0, branch_taken0, illegal0, state0};

    main_control_fsm #(.ILLEGAL_HALT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .lt(lt),
        .mem_ready(mem_ready), .alu_op(alu_op), .pc_write(pc_write),
        .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_imm(alu_src_imm),
        .branch_taken(branch_taken), .illegal(illegal), .state(state)
    );

    main_control_fsm #(.ILLEGAL_HALT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .lt(lt),
        .mem_ready(mem_ready), .alu_op(alu_op0), .pc_write(pc_write0),
        .ir_write(ir_write0), .mem_read(mem_read0), .mem_write(mem_write0),
        .reg_write(reg_write0), .mem_to_reg(mem_to_reg0), .alu_src_imm(alu_src_imm0),
        .branch_taken(branch_taken0), .illegal(illegal0), .state(state0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Branch table: opcode, zero, lt, expected taken
    logic [3:0] br_op    [7] = '{4'hC, 4'hC, 4'h9, 4'h9, 4'hA, 4'hB, 4'hB};
    logic       br_zero  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       br_lt    [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       br_taken [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Advance one cycle; checks then happen 3 time units after the edge.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; opcode = 4'h7; zero = 1'b0; lt = 1'b0;
        #1;
        exp = 16'h0000;
        tests++; if (obs !== exp) begin fails++; $display("FAIL reset_hold: got %h expected %h", obs, exp); end
        @(posedge clk);
        #2;
        tests++; if (obs !== exp) begin fails++; $display("FAIL reset_hold_edge: got %h expected %h", obs, exp); end
        rst_n = 1'b1;
        #1;
        exp = MR | PW | IW | 16'd0;
        tests++; if (obs !== exp) begin fails++; $display("FAIL reset_release: got %h expected %h", obs, exp); end
        next_cycle();
        #1;
        exp = 16'd1;
        tests++; if (obs !== exp) begin fails++; $display("FAIL reset_decode: got %h expected %h", obs, exp); end
        rst_n = 1'b0;
        #1;
        exp = 16'h0000;
        tests++; if (obs !== exp) begin fails++; $display("FAIL reset_async: got %h expected %h", obs, exp); end
    endtask

    task automatic test_fetch_wait();
        opcode = 4'h0; mem_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            #1;
            exp = MR | 16'd0;
            tests++; if (obs !== exp) begin fails++; $display("FAIL fetch_wait%0d: got %h expected %h", i, obs, exp); end
            next_cycle();
        end
        mem_ready = 1'b1;
        #1;
        exp = MR | PW | IW | 16'd0;
        tests++; if (obs !== exp) begin fails++; $display("FAIL fetch_ready: got %h expected %h", obs, exp); end
        next_cycle();
        #1;
        exp = 16'd1;
        tests++; if (obs !== exp) begin fails++; $display("FAIL rtype_decode: got %h expected %h", obs, exp); end
        next_cycle();
        #1;
        exp = 16'd2;
        tests++; if (obs !== exp) begin fails++; $display("FAIL rtype_exec: got %h expected %h", obs, exp); end
        next_cycle();
        #1;
        exp = RW | 16'd4;
        tests++; if (obs !== exp) begin fails++; $display("FAIL rtype_wb: got %h expected %h", obs, exp); end
        next_cycle();
        #1;
        exp = MR | PW | IW | 16'd0;
        tests++; if (obs !== exp) begin fails++; $display("FAIL rtype_refetch: got %h expected %h", obs, exp); end
    endtask

    task automatic test_lw();
        opcode = 4'h7; mem_ready = 1'b1;
        do_reset();
        #1;
        exp = MR | PW | IW | 16'd0;
        tests++; if (obs !== exp) begin fails++; $display("FAIL lw_fetch: got %h expected %h", obs, exp); end
        next_cycle();
        #1;
        exp = 16'd1;
        tests++; if (obs !== exp) begin fails++; $display("FAIL lw_decode: got %h expected %h", obs, exp); end
        next_cycle();
        #1;
        exp = 16'h7000 | ASI | 16'd2;
        tests++; if (obs !== exp) begin fails++; $display("FAIL lw_exec: got %h expected %h", obs, exp); end
        next_cycle();
        mem_ready = 1'b0;
        #1;
        exp = MR | ASI | 16'd3;
        tests++; if (obs !== exp) begin fails++; $display("FAIL lw_mem_wait: got %h expected %h", obs, exp); end
        next_cycle();
        #1;
        tests++; if (obs !== exp) begin fails++; $display("FAIL lw_mem_hold: got %h expected %h", obs, exp); end
        mem_ready = 1'b1;
        next_cycle();
        #1;
        exp = RW | MTR | 16'd4;
        tests++; if (obs !== exp) begin fails++; $display("FAIL lw_wb: got %h expected %h", obs, exp); end
        next_cycle();
        #1;
        exp = MR | PW | IW | 16'd0;
        tests++; if (obs !== exp) begin fails++; $display("FAIL lw_refetch: got %h expected %h", obs, exp); end
    endtask

    task automatic test_branch();
        mem_ready = 1'b1; opcode = 4'hC;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            opcode = br_op[i]; zero = 1'b0; lt = 1'b0;
            #1;
            exp = MR | PW | IW | 16'd0;
            tests++; if (obs !== exp) begin fails++; $display("FAIL br%0d_fetch: got %h expected %h", i, obs, exp); end
            next_cycle();
            #1;
            exp = 16'd1;
            tests++; if (obs !== exp) begin fails++; $display("FAIL br%0d_decode: got %h expected %h", i, obs, exp); end
            next_cycle();
            zero = br_zero[i]; lt = br_lt[i];
            #1;
            exp = {br_op[i], 12'h000} | 16'd2;
            if (br_taken[i]) exp = exp | PW | BT;
            tests++; if (obs !== exp) begin fails++; $display("FAIL br%0d_exec: got %h expected %h", i, obs, exp); end
            next_cycle();
        end
        #1;
        exp = MR | PW | IW | 16'd0;
        tests++; if (obs !== exp) begin fails++; $display("FAIL br_refetch: got %h expected %h", obs, exp); end
    endtask

    task automatic test_illegal();
        opcode = 4'h5; mem_ready = 1'b1; zero = 1'b0; lt = 1'b0;
        do_reset();
        next_cycle();
        #1;
        exp = IL | 16'd1;
        tests++; if (obs !== exp) begin fails++; $display("FAIL ill_decode: got %h expected %h", obs, exp); end
        tests++; if (obs0 !== exp) begin fails++; $display("FAIL ill_decode_skip: got %h expected %h", obs0, exp); end
        next_cycle();
        #1;
        exp = MR | PW | IW | 16'd0;
        tests++; if (obs0 !== exp) begin fails++; $display("FAIL ill_skip_fetch: got %h expected %h", obs0, exp); end
        for (int i = 0; i < 10; i++) begin
            mem_ready = i[0];
            #1;
            exp = IL | 16'd5;
            tests++; if (obs !== exp) begin fails++; $display("FAIL ill_halt%0d: got %h expected %h", i, obs, exp); end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_sw();
        opcode = 4'h8; mem_ready = 1'b1;
        do_reset();
        next_cycle();
        next_cycle();
        #1;
        exp = 16'h8000 | ASI | 16'd2;
        tests++; if (obs !== exp) begin fails++; $display("FAIL sw_exec: got %h expected %h", obs, exp); end
        next_cycle();
        mem_ready = 1'b0;
        #1;
        exp = MW | ASI | 16'd3;
        tests++; if (obs !== exp) begin fails++; $display("FAIL sw_mem_wait: got %h expected %h", obs, exp); end
        rst_n = 1'b0;
        #1;
        exp = 16'h0000;
        tests++; if (obs !== exp) begin fails++; $display("FAIL sw_reset_drop: got %h expected %h", obs, exp); end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        exp = MR | 16'd0;
        tests++; if (obs !== exp) begin fails++; $display("FAIL sw_post_reset: got %h expected %h", obs, exp); end
        next_cycle();
        #1;
        tests++; if (obs !== exp) begin fails++; $display("FAIL sw_post_reset2: got %h expected %h", obs, exp); end
        // Complete a store normally: MEM with mem_ready=1 returns to FETCH.
        mem_ready = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        #1;
        exp = MW | ASI | 16'd3;
        tests++; if (obs !== exp) begin fails++; $display("FAIL sw_mem_done: got %h expected %h", obs, exp); end
        next_cycle();
        #1;
        exp = MR | PW | IW | 16'd0;
        tests++; if (obs !== exp) begin fails++; $display("FAIL sw_refetch: got %h expected %h", obs, exp); end
    endtask

    task automatic test_latched_opcode();
        opcode = 4'h1; mem_ready = 1'b1;
        do_reset();
        next_cycle();
        next_cycle();
        opcode = 4'h7;
        #1;
        exp = 16'h1000 | ASI | 16'd2;
        tests++; if (obs !== exp) begin fails++; $display("FAIL latch_exec: got %h expected %h", obs, exp); end
        next_cycle();
        opcode = 4'hF;
        #1;
        exp = RW | 16'd4;
        tests++; if (obs !== exp) begin fails++; $display("FAIL latch_wb: got %h expected %h", obs, exp); end
    endtask

    initial begin
        rst_n = 1'b0; opcode = 4'h0; zero = 1'b0; lt = 1'b0; mem_ready = 1'b0;
        #2;
        test_reset();
        test_fetch_wait();
        test_lw();
        test_branch();
        test_illegal();
        test_reset_mid_sw();
        test_latched_opcode();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
